pseudo_softmax_seq: RTL and testbench
=====================================

PSEUDO_SOFTMAX_SEQ -- requirements
Module: pseudo_softmax_seq

Interface
REQ-001 Parameter N_ELEM, default 4: vector length per softmax frame (2..8).
REQ-002 Parameter DW, default 3: element, mantissa and exponent width.
REQ-003 Parameter DP_LAT, default 2: datapath latency in clk cycles from dp_data applied to dp_mant/dp_exp valid (1..7).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream element valid.
REQ-007 in_ready  output  1  sequencer accepts element this cycle.
REQ-008 in_data  input  DW  unsigned input element.
REQ-009 dp_data  output  DW  operand to pseudo-softmax datapath (max minus element).
REQ-010 dp_mant  input  DW  datapath mantissa result.
REQ-011 dp_exp  input  DW  datapath exponent result.
REQ-012 out_valid  output  1  result element valid.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_mant, out_exp  output  DW each  buffered result pair.
REQ-015 out_last  output  1  high with final element of frame.
REQ-016 busy  output  1  high in any state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, ISSUE, WAIT, DRAIN.
REQ-018 IDLE: in_ready=1; first in_valid&in_ready stores element 0, sets running max, moves to LOAD (or ISSUE if N_ELEM reached).
REQ-019 LOAD: in_ready=1; each handshake stores element at index cnt, max <= max(max, in_data); after N_ELEM-th accept, go to ISSUE next cycle.
REQ-020 In ISSUE and WAIT, in_ready SHALL be 0; no input accepted.
REQ-021 ISSUE: dp_data <= max - buf[idx] (never negative, DW-bit unsigned, no wrap); go to WAIT with latency counter = DP_LAT.
REQ-022 dp_data SHALL hold stable from ISSUE until capture; equals 0 otherwise.
REQ-023 WAIT: decrement counter; at zero capture dp_mant/dp_exp into result buffer[idx]; idx==N_ELEM-1 -> DRAIN, else idx+1 -> ISSUE.
REQ-024 Per element issue-to-capture SHALL be exactly DP_LAT+1 cycles; frame compute time N_ELEM*(DP_LAT+1) cycles after last load.
REQ-025 DRAIN: out_valid=1 with buffer[oidx]; advance oidx only on out_valid&out_ready; out_last=1 when oidx==N_ELEM-1.
REQ-026 out_mant/out_exp/out_last SHALL hold stable while out_valid&!out_ready.
REQ-027 Final DRAIN handshake returns to IDLE; in_ready=1 on the next cycle (no overlap of frames).
REQ-028 All-equal elements SHALL yield dp_data=0 for every element.
REQ-029 in_valid during ISSUE/WAIT/DRAIN SHALL be ignored without loss of buffered data.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear cnt/idx/oidx/latency counter/max to 0.
REQ-031 During and after reset: in_ready=1 (post-deassert), out_valid=0, out_last=0, busy=0, dp_data=0, out_mant=0, out_exp=0.
REQ-032 Reset mid-frame SHALL discard the partial frame; buffer contents need not be cleared but never re-emitted.

Structure
REQ-033 Shared package pseudo_softmax_pkg SHALL hold the FSM state enum, DW default and DP_LAT default.
REQ-034 Element and result buffers SHALL be one sub-module, softmax_frame_buf (N_ELEM x DW write-by-index, read-by-index register file).
REQ-035 Datapath SHALL remain external; sequencer drives/consumes only dp_* ports.

Verification
REQ-036 Load {3,5,1,5}, DP_LAT=2, model datapath as pipe -> dp_data sequence {2,0,4,0}, each held 3 cycles.
REQ-037 out_ready toggling 1,0,1,0 in DRAIN -> 4 results in order, stable while stalled, out_last only on 4th.
REQ-038 Load {7,7,7,7} -> dp_data 0 for all four, out_mant/out_exp equal model(0) x4.
REQ-039 in_valid held 1 throughout -> exactly 4 accepts, in_ready=0 from ISSUE until return to IDLE.
REQ-040 Assert rst during WAIT of element 2 -> next cycle busy=0, out_valid=0, dp_data=0; new frame {0,1,2,3} -> dp_data {3,2,1,0}.
REQ-041 Gaps in in_valid during LOAD (1,0,0,1,1,0,1) -> max and frame identical to back-to-back load.

Source files
------------

// File: rtl/pseudo_softmax_pkg.sv
// pseudo_softmax_pkg: shared FSM state type and parameter defaults for the softmax sequencer.
package pseudo_softmax_pkg;
  localparam int DW_DEF = 3;
  localparam int DP_LAT_DEF = 2;
  localparam int LAT_W = 3;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN} state_e;
endpackage

// File: rtl/pseudo_softmax_seq_if.sv
// pseudo_softmax_seq_if: upstream, datapath and downstream signals of the softmax sequencer.
interface pseudo_softmax_seq_if import pseudo_softmax_pkg::*; #(parameter int DW = DW_DEF);
  logic in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [DW-1:0] in_data, dp_data, dp_mant, dp_exp, out_mant, out_exp;
  modport master (
    output in_valid, in_data, dp_mant, dp_exp, out_ready,
    input in_ready, dp_data, out_valid, out_mant, out_exp, out_last, busy
  );
  modport slave (
    input in_valid, in_data, dp_mant, dp_exp, out_ready,
    output in_ready, dp_data, out_valid, out_mant, out_exp, out_last, busy
  );
endinterface

// File: rtl/softmax_frame_buf.sv
// softmax_frame_buf: N x W register file, one indexed write port and one indexed combinational read.
module softmax_frame_buf #(
  parameter int N = 4,
  parameter int W = 3
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [$clog2(N)-1:0] waddr_i,
  input  logic [W-1:0]         wdata_i,
  input  logic [$clog2(N)-1:0] raddr_i,
  output logic [W-1:0]         rdata_o
);
  logic [W-1:0] mem_q [N];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/pseudo_softmax_seq.sv
// pseudo_softmax_seq: loads a frame, issues max-minus-element to an external datapath, drains results.
module pseudo_softmax_seq import pseudo_softmax_pkg::*; #(
  parameter int N_ELEM = 4,
  parameter int DW = DW_DEF,
  parameter int DP_LAT = DP_LAT_DEF
) (
  input logic clk,
  input logic rst,
  pseudo_softmax_seq_if.slave io
);
  localparam int IW = $clog2(N_ELEM);
  localparam logic [IW-1:0] LAST = IW'(N_ELEM - 1);
  state_e state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, idx_q, idx_d, oidx_q, oidx_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [DW-1:0] max_q, max_d, dp_q, dp_d, elem_rd;
  logic [2*DW-1:0] res_rd;
  logic in_rdy, acc, cap, ohs;
  assign in_rdy = state_q == IDLE || state_q == LOAD;
  assign acc = io.in_valid && in_rdy;
  assign cap = state_q == WAIT && lat_q == LAT_W'(1);
  assign ohs = state_q == DRAIN && io.out_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    oidx_d = oidx_q;
    lat_d = lat_q;
    max_d = acc && (state_q == IDLE || io.in_data > max_q) ? io.in_data : max_q;
    case (state_q)
      IDLE: if (acc) begin
        state_d = LOAD;
        cnt_d = IW'(1);
      end
      LOAD: if (acc) begin
        state_d = cnt_q == LAST ? ISSUE : LOAD;
        cnt_d = cnt_q == LAST ? '0 : cnt_q + IW'(1);
        idx_d = '0;
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d = LAT_W'(DP_LAT);
      end
      WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (cap) begin
          state_d = idx_q == LAST ? DRAIN : ISSUE;
          idx_d = idx_q == LAST ? '0 : idx_q + IW'(1);
        end
      end
      DRAIN: if (ohs) begin
        state_d = oidx_q == LAST ? IDLE : DRAIN;
        oidx_d = oidx_q == LAST ? '0 : oidx_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // operand is registered on entry to ISSUE so it is already applied during the ISSUE cycle
  assign dp_d = state_d == ISSUE ? max_d - elem_rd : state_d == WAIT ? dp_q : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      oidx_q <= '0;
      lat_q <= '0;
      max_q <= '0;
      dp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      oidx_q <= oidx_d;
      lat_q <= lat_d;
      max_q <= max_d;
      dp_q <= dp_d;
    end
  softmax_frame_buf #(.N(N_ELEM), .W(DW)) u_elem (
    .clk(clk), .we_i(acc), .waddr_i(cnt_q), .wdata_i(io.in_data),
    .raddr_i(idx_d), .rdata_o(elem_rd)
  );
  softmax_frame_buf #(.N(N_ELEM), .W(2*DW)) u_res (
    .clk(clk), .we_i(cap), .waddr_i(idx_q), .wdata_i({io.dp_mant, io.dp_exp}),
    .raddr_i(oidx_q), .rdata_o(res_rd)
  );
  assign io.in_ready = in_rdy;
  assign io.dp_data = dp_q;
  assign io.busy = state_q != IDLE;
  assign io.out_valid = state_q == DRAIN;
  assign io.out_last = state_q == DRAIN && oidx_q == LAST;
  assign io.out_mant = state_q == DRAIN ? res_rd[2*DW-1:DW] : '0;
  assign io.out_exp = state_q == DRAIN ? res_rd[DW-1:0] : '0;
endmodule

// File: tb/tb_pseudo_softmax_seq.sv
// tb_pseudo_softmax_seq: directed frames against a frame-level softmax model with a piped datapath.
module tb_pseudo_softmax_seq;
  localparam int N = 4, DW = 3, LAT = 2;
  logic clk = 0, rst = 0;
  int checks = 0, errors = 0, acc_n = 0;
  pseudo_softmax_seq_if #(.DW(DW)) ifc();
  pseudo_softmax_seq #(.N_ELEM(N), .DW(DW), .DP_LAT(LAT)) dut (.clk(clk), .rst(rst), .io(ifc));
  always #5 clk = ~clk;
  typedef struct {logic [DW-1:0] m, e; logic l;} res_t;
  res_t exp_q[$];
  logic [DW-1:0] got_m[$], got_e[$];
  logic [DW-1:0] d_exp [N];
  logic [DW-1:0] pipe [LAT];
  function automatic logic [DW-1:0] fm(logic [DW-1:0] x);
    return DW'(3 * x + 1);
  endfunction
  function automatic logic [DW-1:0] fe(logic [DW-1:0] x);
    return ~x;
  endfunction
  always @(posedge clk) begin
    pipe[0] <= ifc.dp_data;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ifc.dp_mant = fm(pipe[LAT-1]);
  assign ifc.dp_exp = fe(pipe[LAT-1]);
  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, req);
    end
  endtask
  task automatic model(input logic [DW-1:0] e [N]);
    logic [DW-1:0] mx = 0;
    for (int i = 0; i < N; i++) if (e[i] > mx) mx = e[i];
    for (int i = 0; i < N; i++) begin
      d_exp[i] = mx - e[i];
      exp_q.push_back('{fm(d_exp[i]), fe(d_exp[i]), i == N - 1});
    end
  endtask
  always @(negedge clk) begin
    if (!rst && ifc.in_valid && ifc.in_ready) acc_n++;
    if (!rst && ifc.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        chk("out_mant", ifc.out_mant, exp_q[0].m);
        chk("out_exp", ifc.out_exp, exp_q[0].e);
        chk("out_last", ifc.out_last, exp_q[0].l);
        chk("dp_in_drain", ifc.dp_data, 0);
        chk("rdy_in_drain", ifc.in_ready, 0);
        if (ifc.out_ready) begin
          got_m.push_back(ifc.out_mant);
          got_e.push_back(ifc.out_exp);
          exp_q.delete(0);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [DW-1:0] e [N], input logic [7:0] pat, input int plen, input bit hold);
    int i = 0, k = 0, g = 0;
    bit t;
    while (i < N && g < 100) begin
      ifc.in_valid = k < plen ? pat[k] : 1'b1;
      ifc.in_data = ifc.in_valid ? e[i] : 3'd7;
      k++;
      g++;
      @(negedge clk);
      t = ifc.in_valid && ifc.in_ready;
      step();
      if (t) i++;
    end
    if (i < N) chk("load_timeout", i, N);
    ifc.in_valid = hold;
    ifc.in_data = 3'd6;
  endtask
  task automatic compute(input logic [DW-1:0] d [N]);
    for (int k = 0; k < N * (LAT + 1); k++) begin
      @(negedge clk);
      chk("dp_data", ifc.dp_data, d[k / (LAT + 1)]);
      chk("rdy_busy_ov", {ifc.in_ready, ifc.busy, ifc.out_valid}, 3'b010);
      step();
    end
  endtask
  task automatic drain(input logic [7:0] rpat);
    int k = 0;
    got_m.delete();
    got_e.delete();
    while (exp_q.size() > 0 && k < 50) begin
      ifc.out_ready = k < 8 ? rpat[k] : 1'b1;
      k++;
      step();
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    ifc.out_ready = 0;
    ifc.in_valid = 0;
    @(negedge clk);
    chk("idle_after", {ifc.in_ready, ifc.busy, ifc.out_valid, ifc.out_last}, 4'b1000);
    chk("dp_idle", ifc.dp_data, 0);
    step();
  endtask
  initial begin
    logic [DW-1:0] e [N];
    logic [DW-1:0] lm [N], le [N];
    int a0;
    ifc.in_valid = 0;
    ifc.in_data = 0;
    ifc.out_ready = 0;
    #1 rst = 1;
    step();
    @(negedge clk);
    chk("rst_flags", {ifc.in_ready, ifc.busy, ifc.out_valid, ifc.out_last}, 4'b1000);
    chk("rst_data", {ifc.dp_data, ifc.out_mant, ifc.out_exp}, 0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst", {ifc.in_ready, ifc.busy, ifc.out_valid, ifc.dp_data}, {3'b100, 3'd0});
    step();
    e = '{3, 5, 1, 5};
    model(e);
    load(e, 8'hFF, 0, 0);
    compute('{2, 0, 4, 0});
    drain(8'b01010101);
    lm = '{7, 1, 5, 1};
    le = '{5, 7, 3, 7};
    chk("frameA_count", got_m.size(), N);
    for (int i = 0; i < N && i < got_m.size(); i++) begin
      chk("frameA_mant", got_m[i], lm[i]);
      chk("frameA_exp", got_e[i], le[i]);
    end
    e = '{7, 7, 7, 7};
    a0 = acc_n;
    model(e);
    load(e, 8'hFF, 0, 1);
    compute('{0, 0, 0, 0});
    drain(8'hFF);
    chk("hold_accepts", acc_n - a0, N);
    for (int i = 0; i < N && i < got_m.size(); i++) begin
      chk("equal_mant", got_m[i], 1);
      chk("equal_exp", got_e[i], 7);
    end
    e = '{2, 6, 4, 1};
    model(e);
    load(e, 8'b01011001, 7, 0);
    compute('{4, 0, 2, 5});
    drain(8'hFF);
    model(e);
    load(e, 8'hFF, 0, 0);
    compute(d_exp);
    drain(8'b00110011);
    e = '{3, 5, 1, 5};
    model(e);
    load(e, 8'hFF, 0, 0);
    repeat (7) step();
    @(negedge clk);
    chk("dp_pre_rst", ifc.dp_data, 4);
    rst = 1;
    #1;
    exp_q.delete();
    chk("rst_mid", {ifc.in_ready, ifc.busy, ifc.out_valid, ifc.dp_data}, {3'b100, 3'd0});
    step();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_after", {ifc.busy, ifc.out_valid, ifc.dp_data}, 0);
    step();
    e = '{0, 1, 2, 3};
    model(e);
    load(e, 8'hFF, 0, 0);
    compute('{3, 2, 1, 0});
    drain(8'hFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
